// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30
);
  logic                      ireq_valid;
  logic                      ireq_ready;
  logic [WORD_ADDR_BITS-1:0] ireq_addr;
  logic                      iresp_valid;
  logic [CPU_WIDTH-1:0]      iresp_data;

  logic                      dreq_valid;
  logic                      dreq_ready;
  logic [WORD_ADDR_BITS-1:0] dreq_addr;
  logic [CPU_WIDTH-1:0]      dreq_data;
  logic [3:0]                dreq_write;
  logic                      dresp_valid;
  logic [CPU_WIDTH-1:0]      dresp_data;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [WORD_ADDR_BITS-1:0] mem_req_addr;
  logic [CPU_WIDTH-1:0]      mem_req_data;
  logic [3:0]                mem_req_write;
  logic                      mem_resp_valid;
  logic [CPU_WIDTH-1:0]      mem_resp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    input  dreq_valid, dreq_addr, dreq_data, dreq_write,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ireq_ready, iresp_valid, iresp_data,
    output dreq_ready, dresp_valid, dresp_data,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_write
  );

  modport master (
    output ireq_valid, ireq_addr,
    output dreq_valid, dreq_addr, dreq_data, dreq_write,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ireq_ready, iresp_valid, iresp_data,
    input  dreq_ready, dresp_valid, dresp_data,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data requesters; an owner-tag FIFO
// steers each in-order read response back to the port that issued the read.
module mem_port_arbiter #(
  parameter int CPU_WIDTH       = 32,
  parameter int WORD_ADDR_BITS  = 30,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FIXED_PRIO      = 1'b0
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  mem_port_arbiter_if.slave                   bus,
  output logic [$clog2(MAX_OUTSTANDING):0]    o_outstanding,
  output logic                                o_err_resp
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] SEL_I = 1'b0;
  localparam logic [0:0] SEL_D = 1'b1;

  logic             r_lock;
  logic [0:0]       r_locked_sel;
  logic [0:0]       r_last_grant;
  logic [0:0]       r_tags [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err_resp;

  logic [0:0] w_sel;
  logic       w_win_valid;
  logic       w_win_read;
  logic       w_full;
  logic       w_req_valid;
  logic       w_hs;
  logic       w_push;
  logic       w_pop;
  logic       w_spurious;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_sel = SEL_I;
    if (r_lock)
      w_sel = r_locked_sel;
    else if (bus.ireq_valid && bus.dreq_valid)
      w_sel = (FIXED_PRIO || r_last_grant == SEL_I) ? SEL_D : SEL_I;
    else if (bus.dreq_valid)
      w_sel = SEL_D;
  end

  assign w_win_valid = (w_sel == SEL_D) ? bus.dreq_valid : bus.ireq_valid;
  assign w_win_read  = (w_sel == SEL_I) || (bus.dreq_write == 4'b0000);
  assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));

  // Outputs are forced low while reset is asserted so nothing leaks mid-reset.
  assign w_req_valid = i_reset && w_win_valid && !(w_win_read && w_full);
  assign w_hs        = w_req_valid && bus.mem_req_ready;
  assign w_push      = w_hs && w_win_read;
  assign w_pop       = i_reset && bus.mem_resp_valid && (r_count != '0);
  assign w_spurious  = bus.mem_resp_valid && (r_count == '0);

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = (w_sel == SEL_D) ? bus.dreq_addr : bus.ireq_addr;
  assign bus.mem_req_data  = (w_sel == SEL_D) ? bus.dreq_data : '0;
  assign bus.mem_req_write = (w_sel == SEL_D) ? bus.dreq_write : 4'b0000;
  assign bus.ireq_ready    = w_hs && (w_sel == SEL_I);
  assign bus.dreq_ready    = w_hs && (w_sel == SEL_D);

  assign bus.iresp_valid = w_pop && (r_tags[r_rd_ptr] == SEL_I);
  assign bus.dresp_valid = w_pop && (r_tags[r_rd_ptr] == SEL_D);
  assign bus.iresp_data  = bus.mem_resp_data;
  assign bus.dresp_data  = bus.mem_resp_data;

  assign o_outstanding = r_count;
  assign o_err_resp    = r_err_resp;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lock       <= 1'b0;
      r_locked_sel <= SEL_I;
      r_last_grant <= SEL_I;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_resp   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock       <= 1'b0;
        r_last_grant <= w_sel;
      end else if (w_req_valid) begin
        r_lock       <= 1'b1;
        r_locked_sel <= w_sel;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_spurious) r_err_resp <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; r_count gates every read, so stale entries are never seen.
  always_ff @(posedge i_clk) begin
    if (w_push) r_tags[r_wr_ptr] <= w_sel;
  end
endmodule
